// File: rtl/motor_dense_serial_relu_in_if.sv
// Activation, weight-ROM and result signals of the serial dense stage.
// Handshakes: a transfer happens on a rising edge where valid && ready; the source holds data while valid && !ready.
interface motor_dense_serial_relu_in_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 4
) ();
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                 x_valid;
    logic                 x_ready;
    logic [14:0]          x_data;
    logic [AW-1:0]        w_addr;
    logic [N_OUT*16-1:0]  w_data;
    logic [N_OUT*16-1:0]  b_data;
    logic                 y_valid;
    logic                 y_ready;
    logic [N_OUT*16-1:0]  y_data;

    modport slave (
        input  x_valid, x_data, w_data, b_data, y_ready,
        output x_ready, w_addr, y_valid, y_data
    );

    modport master (
        output x_valid, x_data, w_data, b_data, y_ready,
        input  x_ready, w_addr, y_valid, y_data
    );
endinterface

// File: rtl/motor_dense_serial_relu_in.sv
// Serial dense layer: one ufixed<15,6> activation per cycle times a weight row, N_OUT lanes accumulated in parallel.
// Results are acc[24:9] of each lane (ap_fixed<16,7>, floor and wrap) presented as one vector.
module motor_dense_serial_relu_in #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 4,
    parameter int ACC_W = 40
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    motor_dense_serial_relu_in_if.slave   bus,
    output logic [1:0]                    o_dbg_state
);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]              r_state;
    logic                    r_armed;
    logic [AW-1:0]           r_idx;
    logic signed [ACC_W-1:0] r_acc [N_OUT];

    logic signed [ACC_W-1:0] w_bias_ext [N_OUT];
    logic signed [ACC_W-1:0] w_prod_ext [N_OUT];
    logic                    w_accept;
    logic                    w_last;

    assign w_accept     = (r_state == ST_ACC) && bus.x_valid;
    assign w_last       = (r_idx == AW'(N_IN - 1));
    assign bus.x_ready  = (r_state == ST_ACC);
    assign bus.y_valid  = (r_state == ST_OUT);
    assign bus.w_addr   = r_idx;
    assign o_dbg_state  = r_state;

    genvar j;
    generate
        for (j = 0; j < N_OUT; j++) begin : g_lane
            logic signed [15:0] w_b;
            logic signed [15:0] w_w;
            logic signed [16:0] w_x;
            logic signed [32:0] w_p;

            assign w_b = bus.b_data[16*j +: 16];
            assign w_w = bus.w_data[16*j +: 16];
            // Activation is unsigned; a zero sign bit makes the 17x16 product signed-correct.
            assign w_x = {1'b0, bus.x_data};
            assign w_p = w_x * w_w;

            assign w_bias_ext[j] = {{(ACC_W-25){w_b[15]}}, w_b, 9'd0};
            assign w_prod_ext[j] = {{(ACC_W-33){w_p[32]}}, w_p};
            assign bus.y_data[16*j +: 16] = r_acc[j][24:9];
        end
    endgenerate

    // r_armed holds LOAD for one extra edge after reset release so the bias load lands on the 2nd edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_LOAD;
            r_armed <= 1'b0;
            r_idx   <= '0;
            for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                ST_LOAD: begin
                    if (r_armed) begin
                        for (int k = 0; k < N_OUT; k++) r_acc[k] <= w_bias_ext[k];
                        r_idx   <= '0;
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        for (int k = 0; k < N_OUT; k++) r_acc[k] <= r_acc[k] + w_prod_ext[k];
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= ST_OUT;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                ST_OUT: begin
                    // Bias reload on the handshake lets the next vector start without a LOAD cycle.
                    if (bus.y_ready) begin
                        for (int k = 0; k < N_OUT; k++) r_acc[k] <= w_bias_ext[k];
                        r_state <= ST_ACC;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_motor_dense_serial_relu_in.sv
// Randomized bench for the serial dense stage: a plain-arithmetic reference model feeds an expected queue
// that a per-cycle compare process checks, plus literal results for the hand-worked vectors.
module tb_motor_dense_serial_relu_in;
  localparam int N_IN  = 8;
  localparam int N_OUT = 4;
  localparam int VW    = N_OUT * 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  motor_dense_serial_relu_in_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  motor_dense_serial_relu_in #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(40)) dut (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external weight ROM and bias bus
  logic [VW-1:0] wrom [N_IN];
  logic [VW-1:0] bias_v;
  assign bus.w_data = wrom[bus.w_addr];
  assign bus.b_data = bias_v;

  int            cur_x [N_IN];
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] last_y;
  int            n_checks;
  int            n_pass;
  int            stall;
  bit            yr_rand;
  bit            hs_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // reference model: bias*2^9 + sum(x*w), then floor by 2^9 and keep 16 bits
  function automatic logic [VW-1:0] model_y();
    logic [VW-1:0] r;
    longint        a;
    logic [63:0]   t;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      a = longint'($signed(bias_v[16*j +: 16])) * 512;
      for (int k = 0; k < N_IN; k++)
        a += longint'(cur_x[k]) * longint'($signed(wrom[k][16*j +: 16]));
      t = a >>> 9;
      r[16*j +: 16] = t[15:0];
    end
    return r;
  endfunction

  // driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.x_valid = 1'b0;
    @(negedge clk);
    check("rst x_ready", 64'(bus.x_ready), 64'd0);
    check("rst y_valid", 64'(bus.y_valid), 64'd0);
    check("rst y_data",  64'(bus.y_data),  64'd0);
    check("rst w_addr",  64'(bus.w_addr),  64'd0);
    check("rst state",   64'(dbg_state),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("x_ready after 1st edge", 64'(bus.x_ready), 64'd0);
    @(negedge clk);
    check("x_ready after 2nd edge", 64'(bus.x_ready), 64'd1);
  endtask

  task automatic drive_vector(input int n_acc, input int gap_pct);
    bit accepted;
    int budget;
    for (int k = 0; k < n_acc; k++) begin
      accepted = 1'b0;
      budget   = 0;
      while (!accepted) begin
        @(negedge clk);
        bus.x_valid = ($urandom_range(0, 99) >= gap_pct);
        bus.x_data  = 15'(cur_x[k]);
        if (bus.x_valid && bus.x_ready) begin
          accepted = 1'b1;
          check("w_addr", 64'(bus.w_addr), 64'(k));
        end
        budget++;
        if (!accepted && budget > 300) begin
          fail_now("x accept timeout");
          bus.x_valid = 1'b0;
          return;
        end
      end
    end
    if (n_acc == N_IN) exp_q.push_back(model_y());
    @(negedge clk);
    bus.x_valid = 1'b0;
    if (n_acc == N_IN) check("latency y_valid", 64'(bus.y_valid), 64'd1);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) fail_now("drain timeout");
    @(negedge clk);
  endtask

  task automatic fill_x(input int v);
    for (int k = 0; k < N_IN; k++) cur_x[k] = v;
  endtask

  task automatic fill_w(input logic [15:0] v);
    for (int k = 0; k < N_IN; k++) wrom[k] = {N_OUT{v}};
  endtask

  task automatic rand_x();
    for (int k = 0; k < N_IN; k++) cur_x[k] = int'($urandom_range(0, 32767));
  endtask

  task automatic rand_w();
    for (int k = 0; k < N_IN; k++) wrom[k] = {$urandom(), $urandom()};
  endtask

  // scoreboard / compare process, also owns y_ready
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hs_prev     = 1'b0;
      bus.y_ready = 1'b0;
    end else begin
      if (hs_prev) begin
        check("x_ready after y handshake", 64'(bus.x_ready), 64'd1);
        check("y_valid after y handshake", 64'(bus.y_valid), 64'd0);
      end
      hs_prev = 1'b0;
      if (bus.y_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected y_valid");
        else check("y_data", 64'(bus.y_data), 64'(exp_q[0]));
        check("x_ready in OUT", 64'(bus.x_ready), 64'd0);
      end
      if (stall > 0) begin
        bus.y_ready = 1'b0;
        if (bus.y_valid) stall--;
      end else begin
        bus.y_ready = yr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (bus.y_valid && bus.y_ready) begin
        last_y = bus.y_data;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hs_prev = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    stall       = 0;
    yr_rand     = 1'b0;
    hs_prev     = 1'b0;
    rst_n       = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.y_ready = 1'b0;
    last_y      = '0;
    bias_v      = '0;
    fill_w(16'd512);
    fill_x(512);

    // basic: 8 x 1.0 x 1.0 = 8.0
    apply_reset();
    drive_vector(N_IN, 0);
    wait_drain();
    check("basic", 64'(last_y), 64'({N_OUT{16'h1000}}));

    // bias only
    bias_v = {16'h0100, 16'h0100, 16'h0100, 16'hFF00};
    apply_reset();
    fill_x(0);
    drive_vector(N_IN, 0);
    wait_drain();
    check("bias only", 64'(last_y), 64'({16'h0100, 16'h0100, 16'h0100, 16'hFF00}));

    // truncation toward -inf
    bias_v = '0;
    fill_w(16'h0001);
    apply_reset();
    fill_x(1);
    drive_vector(N_IN, 0);
    wait_drain();
    check("trunc +", 64'(last_y), 64'd0);
    fill_w(16'hFFFF);
    drive_vector(N_IN, 0);
    wait_drain();
    check("trunc -", 64'(last_y), 64'({N_OUT{16'hFFFF}}));

    // wrap, no saturation
    fill_w(16'h7FFF);
    fill_x(32767);
    drive_vector(N_IN, 0);
    wait_drain();
    check("wrap", 64'(last_y), 64'({N_OUT{16'hFC00}}));

    // backpressure with gaps, two back-to-back vectors
    bias_v = {$urandom(), $urandom()};
    apply_reset();
    rand_w();
    rand_x();
    stall = 5;
    drive_vector(N_IN, 30);
    rand_x();
    drive_vector(N_IN, 30);
    wait_drain();

    // random traffic with random y_ready
    yr_rand = 1'b1;
    for (int v = 0; v < 6; v++) begin
      rand_x();
      drive_vector(N_IN, 25);
      if (v % 2 == 1) begin
        wait_drain();
        rand_w();
      end
    end
    wait_drain();
    yr_rand = 1'b0;

    // reset mid-vector discards partial sums
    bias_v = '0;
    fill_w(16'd512);
    fill_x(512);
    drive_vector(3, 0);
    apply_reset();
    drive_vector(N_IN, 0);
    wait_drain();
    check("reset mid-vector", 64'(last_y), 64'({N_OUT{16'h1000}}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
